// File: rtl/shuffle_route_arbiter_if.sv
// ---------------------------------------------------------------------------
// shuffle_route_arbiter_if
// Handshake and data bundle for the shuffle/route arbiter.
//   in_valid/in_ready   : upstream handshake for one tag vector
//   in_tag              : destination tag per lane, lane i at [i*SEL_W +: SEL_W]
//   out_valid/out_ready : downstream handshake for one routing result
//   out_sel             : source lane per destination, dest d at [d*SEL_W +: SEL_W]
//   out_hit/out_dup     : per-destination "tagged at least once" / "tagged twice or more"
//   out_perm_ok         : tags formed a full permutation
// The master modport is the traffic generator/consumer side; the slave
// modport is the arbiter side.
// ---------------------------------------------------------------------------
interface shuffle_route_arbiter_if #(
  parameter int N_LANE = 8
);
  localparam int SEL_W = $clog2(N_LANE);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_LANE*SEL_W-1:0]   in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_LANE*SEL_W-1:0]   out_sel;
  logic [N_LANE-1:0]         out_hit;
  logic [N_LANE-1:0]         out_dup;
  logic                      out_perm_ok;

  modport master (
    output in_valid, in_tag, out_ready,
    input  in_ready, out_valid, out_sel, out_hit, out_dup, out_perm_ok
  );

  modport slave (
    input  in_valid, in_tag, out_ready,
    output in_ready, out_valid, out_sel, out_hit, out_dup, out_perm_ok
  );
endinterface

// File: rtl/shuffle_route_arbiter.sv
// ---------------------------------------------------------------------------
// shuffle_route_arbiter
// Two-stage pipeline that inverts a lane->destination tag vector into a
// destination->source-lane select vector, flags missing and duplicated
// destinations, and counts delivered vectors that are not a permutation.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, drops all in-flight vectors
//   bus      : handshake/data bundle (slave side), see shuffle_route_arbiter_if
//   clr_cnt  : synchronous clear of err_cnt, wins over a same-cycle increment
//   err_cnt  : saturating count of delivered non-permutation vectors
// Duplicate destinations resolve to the lowest source lane when PRIO_HIGH=0
// and to the highest when PRIO_HIGH=1.
// ---------------------------------------------------------------------------
module shuffle_route_arbiter #(
  parameter int N_LANE    = 8,
  parameter int PRIO_HIGH = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  shuffle_route_arbiter_if.slave bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int SEL_W = $clog2(N_LANE);
  localparam int TAG_W = N_LANE * SEL_W;

  logic               v1_r;
  logic [TAG_W-1:0]   tag1_r;
  logic               out_valid_r;
  logic [TAG_W-1:0]   sel_r;
  logic [N_LANE-1:0]  hit_r;
  logic [N_LANE-1:0]  dup_r;
  logic               perm_r;
  logic [CNT_W-1:0]   err_cnt_r;

  logic               in_ready_s;
  logic               load1_s;
  logic               load2_s;
  logic [TAG_W-1:0]   sel_s;
  logic [N_LANE-1:0]  hit_s;
  logic [N_LANE-1:0]  dup_s;
  logic               perm_s;

  // Stage 1 may refill whenever stage 2 can take its current content.
  assign in_ready_s = !v1_r || !out_valid_r || bus.out_ready;
  assign load1_s    = bus.in_valid && in_ready_s;
  assign load2_s    = v1_r && (!out_valid_r || bus.out_ready);

  // Invert the stage-1 tag vector: for every destination scan the lanes in
  // ascending order; a later match overwrites the select only when the
  // highest lane is meant to win, and any second match marks a duplicate.
  always_comb begin
    sel_s = {TAG_W{1'b0}};
    hit_s = {N_LANE{1'b0}};
    dup_s = {N_LANE{1'b0}};
    for (int d = 0; d < N_LANE; d++) begin
      for (int i = 0; i < N_LANE; i++) begin
        if (tag1_r[i*SEL_W +: SEL_W] == SEL_W'(d)) begin
          if (!hit_s[d] || (PRIO_HIGH != 0)) begin
            sel_s[d*SEL_W +: SEL_W] = SEL_W'(i);
          end else begin
            sel_s[d*SEL_W +: SEL_W] = sel_s[d*SEL_W +: SEL_W];
          end
          dup_s[d] = hit_s[d];
          hit_s[d] = 1'b1;
        end else begin
          hit_s[d] = hit_s[d];
        end
      end
    end
    perm_s = &hit_s;
  end

  // Pipeline registers: stage-1 tag capture and stage-2 result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      tag1_r      <= {TAG_W{1'b0}};
      out_valid_r <= 1'b0;
      sel_r       <= {TAG_W{1'b0}};
      hit_r       <= {N_LANE{1'b0}};
      dup_r       <= {N_LANE{1'b0}};
      perm_r      <= 1'b0;
    end else begin
      if (load1_s) begin
        v1_r   <= 1'b1;
        tag1_r <= bus.in_tag;
      end else if (load2_s) begin
        v1_r   <= 1'b0;
      end
      // Result data only moves on a stage-2 load, so it holds under stall.
      if (load2_s) begin
        out_valid_r <= 1'b1;
        sel_r       <= sel_s;
        hit_r       <= hit_s;
        dup_r       <= dup_s;
        perm_r      <= perm_s;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Error counter: clear beats increment; increment saturates at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && bus.out_ready && !perm_r &&
                 (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1'b1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_sel     = sel_r;
  assign bus.out_hit     = hit_r;
  assign bus.out_dup     = dup_r;
  assign bus.out_perm_ok = perm_r;
  assign err_cnt         = err_cnt_r;
endmodule

// File: tb/tb_shuffle_route_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shuffle_route_arbiter
// Drives two arbiters with identical stimulus: dut_a (PRIO_HIGH=0, CNT_W=16)
// and dut_b (PRIO_HIGH=1, CNT_W=2). A reference model holds accepted vectors
// in a queue with the cycle at which each may first be shown, derives
// in_ready from pipeline capacity, and computes routing results by counting
// lanes per destination.
// ---------------------------------------------------------------------------
module tb_shuffle_route_arbiter;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int TW = N * SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic          clr_cnt;
  logic [TW-1:0] in_tag;
  logic [15:0]   err_a;
  logic [1:0]    err_b;

  shuffle_route_arbiter_if #(.N_LANE(N)) bus_a ();
  shuffle_route_arbiter_if #(.N_LANE(N)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_tag    = in_tag;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_tag    = in_tag;
  assign bus_b.out_ready = out_ready;

  shuffle_route_arbiter #(.N_LANE(N), .PRIO_HIGH(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .clr_cnt(clr_cnt), .err_cnt(err_a)
  );
  shuffle_route_arbiter #(.N_LANE(N), .PRIO_HIGH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .clr_cnt(clr_cnt), .err_cnt(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tags;
    int            ready;
  } ent_t;

  ent_t          q[$];
  int            cyc = 0;
  logic [TW-1:0] last_tags;
  bit            last_any = 1'b0;
  int            exp_err_a = 0;
  int            exp_err_b = 0;
  bit            init_done = 1'b0;
  int            checks_cnt = 0;
  int            errors_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Routing result from the tag rules: count lanes per destination and pick
  // the lowest or highest contributing lane.
  function automatic void ref_out(input logic [TW-1:0] t, input bit prio,
                                  output logic [TW-1:0] sel, output logic [N-1:0] hit,
                                  output logic [N-1:0] dup, output logic perm);
    int cnt[N];
    int lo[N];
    int hi[N];
    for (int d = 0; d < N; d++) begin
      cnt[d] = 0; lo[d] = N; hi[d] = -1;
    end
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(t[i*SW +: SW]);
      cnt[d]++;
      if (i < lo[d]) lo[d] = i;
      if (i > hi[d]) hi[d] = i;
    end
    sel = '0;
    for (int d = 0; d < N; d++) begin
      hit[d] = (cnt[d] > 0);
      dup[d] = (cnt[d] > 1);
      if (cnt[d] > 0) sel[d*SW +: SW] = prio ? 3'(hi[d]) : 3'(lo[d]);
    end
    perm = (hit == 8'hFF);
  endfunction

  function automatic logic [TW-1:0] identity_tags();
    logic [TW-1:0] t;
    for (int i = 0; i < N; i++) t[i*SW +: SW] = 3'(i);
    return t;
  endfunction

  function automatic logic [TW-1:0] reverse_tags();
    logic [TW-1:0] t;
    for (int i = 0; i < N; i++) t[i*SW +: SW] = 3'(N - 1 - i);
    return t;
  endfunction

  function automatic logic [TW-1:0] all3_tags();
    logic [TW-1:0] t;
    for (int i = 0; i < N; i++) t[i*SW +: SW] = 3'd3;
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_perm();
    int p[N];
    logic [TW-1:0] t;
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j;
      int tmp;
      j = int'($urandom_range(i, 0));
      tmp = p[i]; p[i] = p[j]; p[j] = tmp;
    end
    for (int i = 0; i < N; i++) t[i*SW +: SW] = 3'(p[i]);
    return t;
  endfunction

  // One clock cycle: drive inputs, check DUT state against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic step(input bit v, input logic [TW-1:0] t, input bit ordy,
                      input bit clr, input bit r, output bit acc);
    bit            vis;
    bit            rdy_exp;
    logic [TW-1:0] shown;
    logic [TW-1:0] sa, sb;
    logic [N-1:0]  ha, hb, da, db;
    logic          pa, pb;
    in_valid = v; in_tag = t; out_ready = ordy; clr_cnt = clr; rst = r;
    @(negedge clk);
    vis     = (q.size() > 0) && (q[0].ready <= cyc);
    rdy_exp = (q.size() < 2) || (vis && ordy);
    if (init_done) begin
      if (vis || last_any) begin
        shown = vis ? q[0].tags : last_tags;
        ref_out(shown, 1'b0, sa, ha, da, pa);
        ref_out(shown, 1'b1, sb, hb, db, pb);
      end else begin
        sa = '0; ha = '0; da = '0; pa = 1'b0;
        sb = '0; hb = '0; db = '0; pb = 1'b0;
      end
      chk("a_out_valid", 64'(bus_a.out_valid), 64'(vis));
      chk("a_out_sel",   64'(bus_a.out_sel),   64'(sa));
      chk("a_out_hit",   64'(bus_a.out_hit),   64'(ha));
      chk("a_out_dup",   64'(bus_a.out_dup),   64'(da));
      chk("a_perm_ok",   64'(bus_a.out_perm_ok), 64'(pa));
      chk("b_out_valid", 64'(bus_b.out_valid), 64'(vis));
      chk("b_out_sel",   64'(bus_b.out_sel),   64'(sb));
      chk("b_out_hit",   64'(bus_b.out_hit),   64'(hb));
      chk("b_out_dup",   64'(bus_b.out_dup),   64'(db));
      chk("b_perm_ok",   64'(bus_b.out_perm_ok), 64'(pb));
      chk("a_err_cnt",   64'(err_a), 64'(exp_err_a));
      chk("b_err_cnt",   64'(err_b), 64'(exp_err_b));
      if (!r) begin
        chk("a_in_ready", 64'(bus_a.in_ready), 64'(rdy_exp));
        chk("b_in_ready", 64'(bus_b.in_ready), 64'(rdy_exp));
      end
    end
    acc = !r && v && rdy_exp;
    if (r) begin
      q.delete();
      last_any  = 1'b0;
      exp_err_a = 0;
      exp_err_b = 0;
      init_done = 1'b1;
    end else begin
      if (vis && ordy) begin
        ref_out(q[0].tags, 1'b0, sa, ha, da, pa);
        if (clr) begin
          exp_err_a = 0; exp_err_b = 0;
        end else if (!pa) begin
          if (exp_err_a < 65535) exp_err_a++;
          if (exp_err_b < 3) exp_err_b++;
        end
        last_tags = q[0].tags;
        last_any  = 1'b1;
        void'(q.pop_front());
      end else if (clr) begin
        exp_err_a = 0; exp_err_b = 0;
      end
      if (acc) q.push_back('{tags: t, ready: cyc + 2});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
  endtask

  initial begin
    bit            a;
    int            nacc;
    int            idx;
    int            guard;
    logic [TW-1:0] vecs[4];

    // Reset with traffic offered: nothing may be accepted.
    for (int k = 0; k < 3; k++) step(1'b1, rand_perm(), 1'($urandom_range(1, 0)), 1'b0, 1'b1, a);
    idle(2);

    // Identity, then reverse and identity back to back, then all lanes to 3.
    step(1'b1, identity_tags(), 1'b1, 1'b0, 1'b0, a);
    idle(3);
    step(1'b1, reverse_tags(), 1'b1, 1'b0, 1'b0, a);
    step(1'b1, identity_tags(), 1'b1, 1'b0, 1'b0, a);
    idle(3);
    step(1'b1, all3_tags(), 1'b1, 1'b0, 1'b0, a);
    idle(3);
    chk("all3_err_a", 64'(err_a), 64'd1);

    // Backpressure: four vectors offered while the output is stalled.
    for (int k = 0; k < 4; k++) vecs[k] = rand_perm();
    idx = 0; nacc = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, vecs[idx], 1'b0, 1'b0, 1'b0, a);
      if (a) begin idx++; nacc++; end
    end
    chk("bp_accepted", 64'(nacc), 64'd2);
    guard = 0;
    while (idx < 4 && guard < 20) begin
      step(1'b1, vecs[idx], 1'b1, 1'b0, 1'b0, a);
      if (a) idx++;
      guard++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd4);
    idle(4);

    // Saturation of the narrow counter, then clear coincident with a bad handshake.
    for (int k = 0; k < 5; k++) step(1'b1, all3_tags(), 1'b1, 1'b0, 1'b0, a);
    idle(3);
    chk("sat_err_b", 64'(err_b), 64'd3);
    step(1'b1, all3_tags(), 1'b1, 1'b0, 1'b0, a);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    chk("clr_err_a", 64'(err_a), 64'd0);
    chk("clr_err_b", 64'(err_b), 64'd0);
    idle(2);

    // Reset with both stages full: nothing stale may follow.
    step(1'b1, rand_perm(), 1'b0, 1'b0, 1'b0, a);
    step(1'b1, all3_tags(), 1'b0, 1'b0, 1'b0, a);
    step(1'b1, rand_perm(), 1'b0, 1'b0, 1'b0, a);
    step(1'b1, rand_perm(), 1'b0, 1'b0, 1'b1, a);
    idle(5);

    // Randomized traffic with occasional clear and reset.
    for (int k = 0; k < 3000; k++) begin
      logic [TW-1:0] t;
      if ($urandom_range(1, 0) == 1) t = rand_perm();
      else t = TW'($urandom());
      step(($urandom_range(3, 0) != 0), t, ($urandom_range(9, 0) < 7),
           ($urandom_range(49, 0) == 0), ($urandom_range(199, 0) == 0), a);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end
endmodule
